// File: rtl/pong_pkg.sv
// Shared types and constants for the pong pixel pipeline.
package pong_pkg;

    typedef enum logic [1:0] {L_NONE, L_SCORE, L_BALL, L_WIN} layer_e;

    localparam logic [3:0] GLYPH_CAT = 4'd8;
    localparam logic [3:0] GLYPH_WIN = 4'd9;

    typedef logic [9:0] coord_t;

    // Non-wrapping box test: widened to 11 bits so origin+size never overflows.
    function automatic logic in_range(logic [10:0] p, logic [10:0] org, logic [10:0] size);
        return (p >= org) && ((p - org) < size);
    endfunction

endpackage

// File: rtl/glyph_renderer_if.sv
// Pixel-in / pixel-out bundle for glyph_renderer, including the glyph ROM lookup pair.
interface glyph_renderer_if;
    import pong_pkg::*;

    logic             pix_valid;
    coord_t           pix_x;
    coord_t           pix_y;
    logic             frame_start;
    logic [2:0]       score_l;
    logic [2:0]       score_r;
    coord_t           ball_x;
    coord_t           ball_y;
    logic [1:0]       winner;
    logic [3:0]       glyph_id;
    logic [7:0][15:0] glyph_pic;
    logic             pix_out_valid;
    logic             pix_on;
    layer_e           pix_layer;

    // Timing source / ROM side.
    modport master (
        output pix_valid, pix_x, pix_y, frame_start, score_l, score_r,
        output ball_x, ball_y, winner, glyph_pic,
        input  glyph_id, pix_out_valid, pix_on, pix_layer
    );

    // Renderer side.
    modport slave (
        input  pix_valid, pix_x, pix_y, frame_start, score_l, score_r,
        input  ball_x, ball_y, winner, glyph_pic,
        output glyph_id, pix_out_valid, pix_on, pix_layer
    );

endinterface

// File: rtl/blink_ctrl.sv
// WIN banner blink: counts frames and toggles phase every BLINK_FRAMES frames.
module blink_ctrl #(
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    input  logic winner_active,
    output logic phase
);

    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

    logic [CntW-1:0] count_q, count_d;
    logic            phase_q, phase_d;
    logic            active_q;

    // Next count/phase; a fresh winner restarts the banner visible, overriding frame_start.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (winner_active && !active_q) begin
            count_d = '0;
            phase_d = 1'b1;
        end else if (frame_start) begin
            if (count_q == CntLast) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter, phase and winner-edge history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            phase_q  <= 1'b1;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            phase_q  <= phase_d;
            active_q <= winner_active;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/picture_gen.sv
// Combinational glyph ROM: digits 0..7, cat sprite (8), WIN banner (9).
// 8-wide glyphs sit in bits [7:0]; row 0 is index 7, MSB is the leftmost column.
module picture_gen #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [3:0]             glyph_id,
    output logic [7:0][WIDTH-1:0]  glyph_pic
);

    function automatic logic [7:0][15:0] narrow(logic [63:0] rows);
        logic [7:0][15:0] pic;
        for (int i = 0; i < 8; i++) begin
            pic[i] = {8'h00, rows[i*8 +: 8]};
        end
        return pic;
    endfunction

    logic [7:0][15:0] rows;

    // Bitmap lookup by glyph id.
    always_comb begin
        rows = '0;
        case (glyph_id)
            4'd0:    rows = narrow(64'h3C66_6E76_6666_3C00);
            4'd1:    rows = narrow(64'h1838_1818_1818_7E00);
            4'd2:    rows = narrow(64'h3C66_060C_3060_7E00);
            4'd3:    rows = narrow(64'h3C66_061C_0666_3C00);
            4'd4:    rows = narrow(64'h0C1C_3C6C_7E0C_0C00);
            4'd5:    rows = narrow(64'h7E60_7C06_0666_3C00);
            4'd6:    rows = narrow(64'h1C30_607C_6666_3C00);
            4'd7:    rows = narrow(64'h7E06_0C18_3030_3000);
            4'd8:    rows = narrow(64'h42E7_FFDB_FF7E_2400);
            4'd9:    rows = 128'h8BA2_8932_8932_892A_A92A_A926_D9A2_0000;
            default: rows = '0;
        endcase
        for (int i = 0; i < 8; i++) begin
            glyph_pic[i] = WIDTH'(rows[i]);
        end
    end

endmodule

// File: rtl/glyph_renderer.sv
// Two-stage pixel pipeline: stage 1 classifies the pixel and selects a glyph,
// stage 2 samples the ROM bitmap into pix_on/pix_layer.
module glyph_renderer
    import pong_pkg::*;
#(
    parameter int unsigned LX           = 200,
    parameter int unsigned RX           = 408,
    parameter int unsigned SY           = 16,
    parameter int unsigned DIG_SH       = 2,
    parameter int unsigned WX           = 288,
    parameter int unsigned WY           = 224,
    parameter int unsigned WIN_SH       = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic              clk,
    input  logic              rst,
    glyph_renderer_if.slave   bus
);

    localparam logic [10:0] LxO     = 11'(LX);
    localparam logic [10:0] RxO     = 11'(RX);
    localparam logic [10:0] SyO     = 11'(SY);
    localparam logic [10:0] WxO     = 11'(WX);
    localparam logic [10:0] WyO     = 11'(WY);
    localparam logic [10:0] DigSz   = 11'(8 << DIG_SH);
    localparam logic [10:0] WinW    = 11'(16 << WIN_SH);
    localparam logic [10:0] WinH    = 11'(8 << WIN_SH);
    localparam logic [10:0] BallSz  = 11'd8;

    logic phase;
    logic win_active;

    assign win_active = (bus.winner == 2'd1) || (bus.winner == 2'd2);

    blink_ctrl #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (bus.frame_start),
        .winner_active (win_active),
        .phase         (phase)
    );

    // Widened coordinates and per-object offsets.
    logic [10:0] px, py, bx, by;
    logic [10:0] win_dx, win_dy, ball_dx, ball_dy, l_dx, r_dx, dig_dy;
    logic        win_hit, ball_hit, l_hit, r_hit;

    assign px      = {1'b0, bus.pix_x};
    assign py      = {1'b0, bus.pix_y};
    assign bx      = {1'b0, bus.ball_x};
    assign by      = {1'b0, bus.ball_y};
    assign win_dx  = px - WxO;
    assign win_dy  = py - WyO;
    assign ball_dx = px - bx;
    assign ball_dy = py - by;
    assign l_dx    = px - LxO;
    assign r_dx    = px - RxO;
    assign dig_dy  = py - SyO;

    assign win_hit  = win_active && phase && in_range(px, WxO, WinW) && in_range(py, WyO, WinH);
    assign ball_hit = in_range(px, bx, BallSz) && in_range(py, by, BallSz);
    assign l_hit    = in_range(px, LxO, DigSz) && in_range(py, SyO, DigSz);
    assign r_hit    = in_range(px, RxO, DigSz) && in_range(py, SyO, DigSz);

    logic       s1_valid_q;
    layer_e     s1_layer_q, s1_layer_d;
    logic [2:0] s1_row_q, s1_row_d;
    logic [3:0] s1_col_q, s1_col_d;
    logic       s1_wide_q, s1_wide_d;
    logic [3:0] glyph_id_q, glyph_id_d;

    // Stage 1 classification in priority order; glyph_id holds when nothing is hit.
    always_comb begin
        s1_layer_d = L_NONE;
        s1_row_d   = '0;
        s1_col_d   = '0;
        s1_wide_d  = 1'b0;
        glyph_id_d = glyph_id_q;
        if (bus.pix_valid) begin
            if (win_hit) begin
                s1_layer_d = L_WIN;
                s1_row_d   = 3'(win_dy >> WIN_SH);
                s1_col_d   = 4'(win_dx >> WIN_SH);
                s1_wide_d  = 1'b1;
                glyph_id_d = GLYPH_WIN;
            end else if (ball_hit) begin
                s1_layer_d = L_BALL;
                s1_row_d   = ball_dy[2:0];
                s1_col_d   = {1'b0, ball_dx[2:0]};
                glyph_id_d = GLYPH_CAT;
            end else if (l_hit) begin
                s1_layer_d = L_SCORE;
                s1_row_d   = 3'(dig_dy >> DIG_SH);
                s1_col_d   = {1'b0, 3'(l_dx >> DIG_SH)};
                glyph_id_d = {1'b0, bus.score_l};
            end else if (r_hit) begin
                s1_layer_d = L_SCORE;
                s1_row_d   = 3'(dig_dy >> DIG_SH);
                s1_col_d   = {1'b0, 3'(r_dx >> DIG_SH)};
                glyph_id_d = {1'b0, bus.score_r};
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_layer_q <= L_NONE;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s1_wide_q  <= 1'b0;
            glyph_id_q <= '0;
        end else begin
            s1_valid_q <= bus.pix_valid;
            s1_layer_q <= s1_layer_d;
            s1_row_q   <= s1_row_d;
            s1_col_q   <= s1_col_d;
            s1_wide_q  <= s1_wide_d;
            glyph_id_q <= glyph_id_d;
        end
    end

    // Bitmap bit for the stage-1 pixel; glyph_pic already reflects glyph_id_q.
    logic [3:0] bit_col;
    logic       pic_bit;

    assign bit_col = s1_wide_q ? (4'd15 - s1_col_q) : (4'd7 - s1_col_q);
    assign pic_bit = bus.glyph_pic[3'd7 - s1_row_q][bit_col];

    logic   out_valid_q;
    logic   out_on_q;
    layer_e out_layer_q;

    // Stage 2 output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_on_q    <= 1'b0;
            out_layer_q <= L_NONE;
        end else begin
            out_valid_q <= s1_valid_q;
            out_on_q    <= (s1_layer_q != L_NONE) && pic_bit;
            out_layer_q <= s1_layer_q;
        end
    end

    assign bus.glyph_id      = glyph_id_q;
    assign bus.pix_out_valid = out_valid_q;
    assign bus.pix_on        = out_on_q;
    assign bus.pix_layer     = out_layer_q;

endmodule
